// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory with a 1-cycle fetch request/response handshake.
// After reset, a clear sequence writes NOP (all zeros) to every word before
// fetches are served. A dedicated load port writes program words at run time.
module inst_mem_sync #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_req_i,
  input  logic [PC_W-1:0]   fetch_pc_i,
  output logic              fetch_ready_o,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_err_o,
  input  logic              inst_ready_i,
  input  logic              load_en_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              inst_err_q, inst_err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              fetch_accept;
  logic              pc_legal;
  logic [AW-1:0]     word_idx;

  // High PC bits must be zero; they are never folded back into the array.
  assign pc_legal = (fetch_pc_i[1:0] == 2'b00) && ((fetch_pc_i >> (AW + 2)) == '0);
  assign word_idx = fetch_pc_i[AW+1:2];

  assign busy_o        = (state_q == StClear);
  assign fetch_ready_o = (state_q == StRun) && !load_en_i && (!inst_valid_q || inst_ready_i);
  assign fetch_accept  = fetch_req_i && fetch_ready_o;

  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_err_o   = inst_err_q;

  // Clear sequencer: walk every index once, then hand over to fetch service.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == StClear) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == AW'(DEPTH - 1)) begin
        state_d = StRun;
      end
    end
  end

  // Single write port: the clear sequence owns it while busy, loads otherwise.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = load_addr_i;
    mem_wdata = load_data_i;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else begin
      mem_we = load_en_i;
    end
  end

  // Response register: capture on accept, drop once consumed, else hold.
  always_comb begin
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_err_d   = inst_err_q;
    if (fetch_accept) begin
      inst_valid_d = 1'b1;
      inst_d       = pc_legal ? mem_q[word_idx] : '0;
      inst_err_d   = !pc_legal;
    end else if (inst_valid_q && inst_ready_i) begin
      inst_valid_d = 1'b0;
    end
  end

  // Control and response state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StClear;
      clr_cnt_q    <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_err_q   <= inst_err_d;
    end
  end

  // Storage is not reset; writes in the reset cycle are discarded.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_inst_mem_sync.sv
// Self-checking bench for inst_mem_sync using a response scoreboard.
module tb_inst_mem_sync;

  logic        clk = 1'b0;
  logic        rst, fetch_req, fetch_ready, inst_valid, inst_err, inst_ready;
  logic        load_en, busy;
  logic [31:0] fetch_pc, inst, load_data;
  logic [4:0]  load_addr;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_mem [32];
  logic [32:0] sb_q [$];
  logic [32:0] exp_r;

  always #5 clk = ~clk;

  inst_mem_sync #(.DATA_W(32), .DEPTH(32), .PC_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .fetch_req_i  (fetch_req),
    .fetch_pc_i   (fetch_pc),
    .fetch_ready_o(fetch_ready),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_err_o   (inst_err),
    .inst_ready_i (inst_ready),
    .load_en_i    (load_en),
    .load_addr_i  (load_addr),
    .load_data_i  (load_data),
    .busy_o       (busy)
  );

  // Expected {err, inst} for a fetch of pc against the bench memory model.
  function automatic logic [32:0] expect_resp(input logic [31:0] pc);
    if (pc[1:0] == 2'b00 && pc[31:7] == 25'd0) return {1'b0, model_mem[pc[6:2]]};
    return {1'b1, 32'h0};
  endfunction

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b0; fetch_pc = '0; inst_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    clk_step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, fetch_ready, inst_valid} !== 3'b100) begin
        n_err++;
        $display("FAIL reset_clear cyc %0d: busy/ready/valid=%b want 100", i,
                 {busy, fetch_ready, inst_valid});
      end
      clk_step();
    end
    @(negedge clk);
    n_vec++;
    if ({busy, fetch_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_done: busy/ready=%b want 01", {busy, fetch_ready});
    end
    fetch_req = 1'b1; fetch_pc = 32'h7C; inst_ready = 1'b1;
    @(negedge clk);
    sb_q.push_back(expect_resp(fetch_pc));
    clk_step();
    fetch_req = 1'b0;
    @(negedge clk);
    exp_r = sb_q.pop_front();
    n_vec++;
    if ({inst_valid, inst_err, inst} !== {1'b1, exp_r}) begin
      n_err++;
      $display("FAIL reset_fetch_7c: got v=%b e=%b %h want e=%b %h", inst_valid, inst_err, inst,
               exp_r[32], exp_r[31:0]);
    end
    clk_step();
  endtask

  // Streams the given PCs back to back with inst_ready high.
  task automatic stream(input string name, input logic [31:0] pcs [$]);
    inst_ready = 1'b1;
    for (int i = 0; i <= pcs.size(); i++) begin
      if (i < pcs.size()) begin
        fetch_req = 1'b1; fetch_pc = pcs[i];
      end else begin
        fetch_req = 1'b0;
      end
      @(negedge clk);
      if (i < pcs.size()) begin
        n_vec++;
        if (fetch_ready !== 1'b1) begin
          n_err++;
          $display("FAIL %s ready %0d: got %b want 1", name, i, fetch_ready);
        end
        sb_q.push_back(expect_resp(fetch_pc));
      end
      if (i > 0) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL %s resp %0d: got empty scoreboard want entry", name, i);
        end else begin
          exp_r = sb_q.pop_front();
          if ({inst_valid, inst_err, inst} !== {1'b1, exp_r}) begin
            n_err++;
            $display("FAIL %s resp %0d: got v=%b e=%b %h want v=1 e=%b %h", name, i, inst_valid,
                     inst_err, inst, exp_r[32], exp_r[31:0]);
          end
        end
      end
      clk_step();
    end
    @(negedge clk);
    n_vec++;
    if (inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s drain: inst_valid=%b want 0", name, inst_valid);
    end
  endtask

  task automatic test_load_stream();
    logic [31:0] w [4] = '{32'h24010001, 32'h00011100, 32'h00411821, 32'h08000000};
    logic [31:0] pcs [$] = '{32'h00, 32'h04, 32'h08, 32'h0C};
    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1; load_addr = 5'(i); load_data = w[i];
      model_mem[i] = w[i];
      clk_step();
    end
    load_en = 1'b0;
    stream("load_stream", pcs);
  endtask

  task automatic test_backpressure();
    fetch_req = 1'b1; fetch_pc = 32'h04; inst_ready = 1'b0;
    @(negedge clk);
    sb_q.push_back(expect_resp(fetch_pc));
    clk_step();
    fetch_pc = 32'h08;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({fetch_ready, inst_valid, inst_err, inst} !== {2'b01, 33'h0_0001_1100}) begin
        n_err++;
        $display("FAIL stall %0d: got rdy=%b v=%b e=%b %h want rdy=0 v=1 e=0 00011100", i,
                 fetch_ready, inst_valid, inst_err, inst);
      end
      clk_step();
    end
    inst_ready = 1'b1;
    @(negedge clk);
    exp_r = sb_q.pop_front();
    n_vec++;
    if ({fetch_ready, inst_valid, inst_err, inst} !== {2'b11, exp_r}) begin
      n_err++;
      $display("FAIL release: got rdy=%b v=%b %h want rdy=1 v=1 %h", fetch_ready, inst_valid,
               inst, exp_r[31:0]);
    end
    sb_q.push_back(expect_resp(fetch_pc));
    clk_step();
    fetch_req = 1'b0;
    @(negedge clk);
    exp_r = sb_q.pop_front();
    n_vec++;
    if ({inst_valid, inst_err, inst} !== {1'b1, exp_r} || inst !== 32'h00411821) begin
      n_err++;
      $display("FAIL after_release: got v=%b e=%b %h want v=1 e=0 00411821", inst_valid,
               inst_err, inst);
    end
    clk_step();
  endtask

  task automatic test_illegal();
    logic [31:0] pcs [$] = '{32'h06, 32'h80, 32'hFFFF_FF84, 32'h00};
    stream("illegal", pcs);
  endtask

  task automatic test_load_priority();
    load_en = 1'b1; load_addr = 5'd1; load_data = 32'hAC250013;
    fetch_req = 1'b1; fetch_pc = 32'h04; inst_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (fetch_ready !== 1'b0) begin
      n_err++;
      $display("FAIL load_priority: fetch_ready=%b want 0", fetch_ready);
    end
    clk_step();
    model_mem[1] = 32'hAC250013;
    load_en = 1'b0;
    @(negedge clk);
    n_vec++;
    if (fetch_ready !== 1'b1) begin
      n_err++;
      $display("FAIL raw_accept: fetch_ready=%b want 1", fetch_ready);
    end
    sb_q.push_back(expect_resp(fetch_pc));
    clk_step();
    fetch_req = 1'b0;
    @(negedge clk);
    exp_r = sb_q.pop_front();
    n_vec++;
    if ({inst_valid, inst_err, inst} !== {1'b1, exp_r}) begin
      n_err++;
      $display("FAIL raw_data: got v=%b e=%b %h want v=1 e=0 %h", inst_valid, inst_err, inst,
               exp_r[31:0]);
    end
    // Held response must not follow a later write to the same word.
    fetch_req = 1'b1; fetch_pc = 32'h04; inst_ready = 1'b0;
    clk_step();
    sb_q.push_back(expect_resp(fetch_pc));
    fetch_req = 1'b0;
    load_en = 1'b1; load_addr = 5'd1; load_data = 32'hDEADBEEF;
    clk_step();
    load_en = 1'b0;
    model_mem[1] = 32'hDEADBEEF;
    @(negedge clk);
    exp_r = sb_q.pop_front();
    n_vec++;
    if ({inst_valid, inst_err, inst} !== {1'b1, exp_r}) begin
      n_err++;
      $display("FAIL held_vs_write: got v=%b %h want v=1 %h", inst_valid, inst, exp_r[31:0]);
    end
    inst_ready = 1'b1;
    clk_step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] pcs [$] = '{32'h04, 32'h00, 32'h0C};
    fetch_req = 1'b1; fetch_pc = 32'h04; inst_ready = 1'b0;
    clk_step();
    fetch_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (inst_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pending: inst_valid=%b want 1", inst_valid);
    end
    rst = 1'b1; load_en = 1'b1; load_addr = 5'd2; load_data = 32'h12345678;
    clk_step();
    rst = 1'b0; load_en = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    for (int i = 0; i < 32; i++) begin
      // A load attempted during the clear must be ignored.
      if (i == 31) begin
        load_en = 1'b1; load_addr = 5'd0; load_data = 32'hFFFF_0000;
      end
      @(negedge clk);
      n_vec++;
      if ({busy, fetch_ready, inst_valid} !== 3'b100) begin
        n_err++;
        $display("FAIL mid_clear cyc %0d: busy/ready/valid=%b want 100", i,
                 {busy, fetch_ready, inst_valid});
      end
      clk_step();
    end
    load_en = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_done: busy=%b want 0", busy);
    end
    stream("mid_reset", pcs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_stream();
    test_backpressure();
    test_illegal();
    test_load_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
- Parametrised, synchronous successor to the fixed-size asynchronous instruction ROM.
- Holds DEPTH instruction words in writable storage.
- Serves instruction fetches from the CPU fetch stage over a request/response handshake with 1-cycle latency.
- Accepts program loading at run time through a dedicated load port. After reset it clears itself to NOP before it serves any fetch.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 32, number of instruction words; must be a power of two, minimum 2.
- PC_W, 32, width of the byte-addressed fetch PC.
- AW, log2(DEPTH), word-index width; derived, not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_req  in  1  fetch request, valid for this cycle.
- fetch_pc  in  PC_W  byte address of the instruction to fetch.
- fetch_ready  out  1  block accepts a fetch this cycle.
- inst_valid  out  1  response word is present on inst.
- inst  out  DATA_W  fetched instruction.
- inst_err  out  1  response belongs to a misaligned or out-of-range PC; qualified by inst_valid.
- inst_ready  in  1  consumer takes the response this cycle.
- load_en  in  1  write one program word this cycle.
- load_addr  in  AW  word index to write.
- load_data  in  DATA_W  word to write.
- busy  out  1  clear sequence is in progress.

Behaviour:
- Reset (rst=1 at an edge):
  - state<=CLEAR, clr_cnt<=0.
  - inst_valid<=0, inst<=0, inst_err<=0.
  - busy=1 from the cycle after the reset edge.
  - Storage contents are not reset directly.
- State CLEAR:
  - Each cycle writes 0 (encodes sll $0,$0,0 = NOP) to mem[clr_cnt], then clr_cnt++.
  - After the cycle that writes index DEPTH-1, go to RUN. CLEAR lasts exactly DEPTH cycles.
  - In CLEAR: busy=1, fetch_ready=0. load_en is ignored; no write occurs.
- State RUN:
  - busy=0.
  - fetch_ready = !load_en && (!inst_valid || inst_ready), combinational.
- Fetch acceptance: fetch_req && fetch_ready at an edge.
  - Next cycle: inst_valid=1.
  - inst = mem[fetch_pc[AW+1:2]] when the PC is legal, else 0.
- PC legality:
  - Legal when fetch_pc[1:0]==0 and fetch_pc[PC_W-1:AW+2]==0.
  - Illegal PC: inst=0, inst_err=1. No wrap-around of high PC bits into the array.
- Response hold:
  - inst, inst_err and inst_valid stay stable until the edge where inst_valid && inst_ready.
  - That edge clears inst_valid unless a new fetch is accepted at the same edge.
  - If a new fetch is accepted at that edge, the next response follows back-to-back.
  - Throughput is 1 instruction/cycle when inst_ready is held at 1.
- Load:
  - In RUN with load_en=1: mem[load_addr]<=load_data at the edge.
  - No fetch is accepted in that cycle (load has priority).
  - A response already held in inst is unaffected by a later write to the same address.
  - Write-then-read: a fetch accepted on the cycle after the write returns the new data.
- Reset mid-operation (in CLEAR or RUN):
  - Any pending response is dropped.
  - The clear sequence restarts from index 0.
  - Loads issued during that reset cycle are discarded.
- Storage: DEPTH x DATA_W registers (or inferred RAM). Single write port, shared between the CLEAR and load paths; CLEAR owns it while busy=1.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 1 cycle, then fetch_req=0.
  - Required: busy=1 for exactly 32 cycles, fetch_ready=0 throughout; then busy=0 and fetch_ready=1.
  - Follow-up: fetch pc=0x7C returns inst=0x00000000, inst_err=0.
- Load and stream:
  - Stimulus: load words 0..3 = 0x24010001, 0x00011100, 0x00411821, 0x08000000. Then fetch pc 0x00, 0x04, 0x08, 0x0C on consecutive cycles with inst_ready=1.
  - Required: the four words come back on 4 consecutive cycles, first one 1 cycle after the first request, inst_err=0.
- Backpressure:
  - Stimulus: fetch pc=0x04 with inst_ready=0 for 3 cycles, fetch_req held high with pc=0x08.
  - Required: fetch_ready=0 during the stall; inst=0x00011100 held stable.
  - Release: on the inst_ready=1 edge pc=0x08 is accepted, and the next cycle inst=0x00411821.
- Illegal PCs:
  - Stimulus: fetch pc=0x06 (misaligned), then pc=0x80 (out of range at DEPTH=32).
  - Required: each response has inst=0, inst_err=1.
  - Follow-up: a subsequent fetch of pc=0x00 has inst_err=0.
- Load priority and read-after-write:
  - Stimulus: load_en=1 with addr 1, data 0xAC250013, and fetch_req=1 pc=0x04 in the same cycle.
  - Required: fetch_ready=0 in that cycle. The fetch is accepted the next cycle and returns 0xAC250013.
- Reset mid-stream:
  - Stimulus: assert rst while inst_valid=1.
  - Required: inst_valid=0 the next cycle, busy=1 for 32 cycles.
  - Follow-up: pc=0x04 then returns 0x00000000, confirming the previously loaded word was cleared.
